// File: rtl/ble_cmd_sender.sv
// Host-side command serializer: sends {cmd, data} as three 8N1 UART bytes on TX,
// then waits for a single response byte on RX or gives up after RESP_TIMEOUT clocks.
module ble_cmd_sender #(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter logic [23:0] RESP_TIMEOUT = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        timeout
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BaudLast = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BaudHalf = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitResp} state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

  state_e        state_q, state_d;
  logic [23:0]   shadow_q, shadow_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [1:0]    tx_byte_q, tx_byte_d;
  logic [23:0]   tmo_q, tmo_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          cmd_sent_q, cmd_sent_d;
  logic          resp_rdy_q, resp_rdy_d;
  logic [7:0]    resp_q, resp_d;
  logic          timeout_q, timeout_d;

  logic          rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_done;

  // Line level for a given byte/bit position of the 30-bit command frame.
  function automatic logic frame_bit(logic [23:0] sh, logic [1:0] byte_i, logic [3:0] bit_i);
    logic [7:0] sel;
    logic [3:0] idx;
    unique case (byte_i)
      2'd0:    sel = sh[23:16];
      2'd1:    sel = sh[15:8];
      default: sel = sh[7:0];
    endcase
    idx = bit_i - 4'd1;
    if (bit_i == 4'd0)      frame_bit = 1'b0;
    else if (bit_i >= 4'd9) frame_bit = 1'b1;
    else                    frame_bit = sel[idx[2:0]];
  endfunction

  // Receiver next state: start re-check at mid-bit, then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RxStart;
          rx_baud_d  = '0;
        end
      end
      RxStart: begin
        if (rx_baud_q == BaudHalf) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? RxIdle : RxData;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_baud_q == BaudLast) begin
          rx_baud_d = '0;
          if (rx_sync2_q) begin
            rx_done    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_state_d = RxWaitHigh;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        if (rx_sync2_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Receiver registers, including the two-flop synchronizer and edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Main FSM next state, transmit counters and registered output values.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tmo_d      = '0;
    busy_d     = busy_q;
    cmd_sent_d = 1'b0;
    resp_rdy_d = resp_rdy_q;
    resp_d     = resp_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_baud_d = '0;
        tx_bit_d  = '0;
        tx_byte_d = '0;
        if (snd_cmd) begin
          shadow_d   = {cmd, data};
          resp_rdy_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (tx_baud_q == BaudLast) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tx_byte_q == 2'd2) begin
              tx_byte_d  = '0;
              cmd_sent_d = 1'b1;
              state_d    = StWaitResp;
            end else begin
              tx_byte_d = tx_byte_q + 2'd1;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      StWaitResp: begin
        tmo_d = tmo_q + 24'd1;
        // A byte finishing on the timeout cycle takes priority.
        if (rx_done) begin
          resp_d     = rx_shift_q;
          resp_rdy_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else if (tmo_q == RESP_TIMEOUT - 24'd1) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    tx_d = (state_d == StSend) ? frame_bit(shadow_d, tx_byte_d, tx_bit_d) : 1'b1;
  end

  // Main FSM and output registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tmo_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
      resp_rdy_q <= 1'b0;
      resp_q     <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tmo_q      <= tmo_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cmd_sent_q <= cmd_sent_d;
      resp_rdy_q <= resp_rdy_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ble_cmd_sender.sv
// Randomized bench for ble_cmd_sender with a frame-level reference model and
// directed literal checks on frame contents, latencies and response handling.
module tb_ble_cmd_sender;

  localparam int B     = 16;
  localparam int TO    = 2000;
  // Start-bit edge to byte-complete edge: sync + edge detect, then mid-stop sample.
  localparam int RXLAT = 3 + B / 2 + 9 * B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        RX = 1'b1;
  logic        TX, busy, cmd_sent, resp_rdy, timeout;
  logic [7:0]  resp;

  ble_cmd_sender #(
    .BAUD_DIV    (B),
    .RESP_TIMEOUT(24'(TO))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .snd_cmd (snd_cmd),
    .cmd     (cmd),
    .data    (data),
    .RX      (RX),
    .TX      (TX),
    .busy    (busy),
    .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy),
    .resp    (resp),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tmo_seen = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc;
  int          m_mode;  // 0 idle, 1 sending, 2 awaiting response
  int          m_t, m_w;
  logic [29:0] m_frame;
  logic        m_busy, m_sent, m_rdy, m_tmo, m_tx;
  logic [7:0]  m_resp;
  int          rxq_edge[$];
  logic [7:0]  rxq_val[$];

  // Bit k of the result is the k-th bit on the wire.
  function automatic logic [29:0] build_frame(logic [23:0] w);
    logic [29:0] f;
    logic [7:0]  b;
    for (int i = 0; i < 3; i++) begin
      b = w[23 - 8 * i -: 8];
      f[10 * i] = 1'b0;
      for (int k = 0; k < 8; k++) f[10 * i + 1 + k] = b[k];
      f[10 * i + 9] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic rx_due(int edge_n);
    return (rxq_edge.size() > 0) && (rxq_edge[0] == edge_n);
  endfunction

  assign m_tx = (m_mode == 1) ? m_frame[m_t / B] : 1'b1;

  // Model advance on each clock edge; cyc+1 is the number of the edge being taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      m_mode <= 0;
      m_t    <= 0;
      m_w    <= 0;
      m_busy <= 1'b0;
      m_sent <= 1'b0;
      m_rdy  <= 1'b0;
      m_tmo  <= 1'b0;
      m_resp <= 8'h00;
      rxq_edge.delete();
      rxq_val.delete();
    end else begin
      cyc    <= cyc + 1;
      m_sent <= 1'b0;
      m_tmo  <= 1'b0;
      case (m_mode)
        0: if (snd_cmd) begin
          m_mode  <= 1;
          m_t     <= 0;
          m_frame <= build_frame({cmd, data});
          m_busy  <= 1'b1;
          m_rdy   <= 1'b0;
        end
        1: if (m_t == 30 * B - 1) begin
          m_mode <= 2;
          m_sent <= 1'b1;
          m_w    <= 0;
        end else begin
          m_t <= m_t + 1;
        end
        default: if (rx_due(cyc + 1)) begin
          m_resp <= rxq_val[0];
          m_rdy  <= 1'b1;
          m_busy <= 1'b0;
          m_mode <= 0;
        end else if (m_w == TO - 1) begin
          m_tmo  <= 1'b1;
          m_busy <= 1'b0;
          m_mode <= 0;
        end else begin
          m_w <= m_w + 1;
        end
      endcase
      if (rx_due(cyc + 1)) begin
        void'(rxq_edge.pop_front());
        void'(rxq_val.pop_front());
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("tx", TX, m_tx);
    check("busy", busy, m_busy);
    check("cmd_sent", cmd_sent, m_sent);
    check("resp_rdy", resp_rdy, m_rdy);
    check("resp", resp, m_resp);
    check("timeout", timeout, m_tmo);
    if (timeout === 1'b1) tmo_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(logic [7:0] c, logic [15:0] d, output int acc);
    cmd     = c;
    data    = d;
    snd_cmd = 1'b1;
    tick(1);
    snd_cmd = 1'b0;
    cmd     = 8'($urandom);
    data    = 16'($urandom);
    acc     = cyc;
  endtask

  task automatic send_rx(logic [7:0] v, logic stop);
    RX = 1'b0;
    if (stop) begin
      rxq_edge.push_back(cyc + RXLAT);
      rxq_val.push_back(v);
    end
    tick(B);
    for (int k = 0; k < 8; k++) begin
      RX = v[k];
      tick(B);
    end
    RX = stop;
    tick(B);
    RX = 1'b1;
    tick(2);
  endtask

  task automatic wait_sent(output int e);
    e = -1;
    for (int i = 0; i < 700 && e < 0; i++) begin
      if (cmd_sent === 1'b1) e = cyc;
      else tick(1);
    end
    if (e < 0) begin
      check("cmd_sent_wait", 32'd0, 32'd1);
      e = cyc;
    end
  endtask

  task automatic wait_idle(int budget);
    int i;
    for (i = 0; i < budget && busy !== 1'b0; i++) tick(1);
    if (i >= budget) check("idle_wait", busy, 1'b0);
  endtask

  // Samples the 30 bits mid-period starting from the acceptance cycle.
  task automatic capture(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2);
    logic [29:0] f;
    tick(B / 2);
    for (int j = 0; j < 30; j++) begin
      f[j] = TX;
      if (j < 29) tick(B);
    end
    for (int i = 0; i < 3; i++) begin
      check("start_bit", f[10 * i], 1'b0);
      check("stop_bit", f[10 * i + 9], 1'b1);
    end
    b0 = f[8:1];
    b1 = f[18:11];
    b2 = f[28:21];
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          a, e, t0;
    logic [7:0]  c0, c1, c2;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("reset_tx", TX, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rdy", resp_rdy, 1'b0);
    check("reset_resp", resp, 8'h00);

    // 1: basic frame and cmd_sent latency
    send_cmd(8'h02, 16'h1234, a);
    check("busy_after_accept", busy, 1'b1);
    capture(c0, c1, c2);
    check("t1_byte0", c0, 8'h02);
    check("t1_byte1", c1, 8'h12);
    check("t1_byte2", c2, 8'h34);
    wait_sent(e);
    check("t1_cmd_sent_lat", 32'(e - a), 32'd480);
    // 2: clean response
    tick(20);
    t0 = tmo_seen;
    send_rx(8'hA5, 1'b1);
    wait_idle(400);
    check("t2_resp", resp, 8'hA5);
    check("t2_rdy", resp_rdy, 1'b1);
    check("t2_busy", busy, 1'b0);
    check("t2_no_timeout", 32'(tmo_seen - t0), 32'd0);

    // 3: no reply -> timeout 2000 clocks after cmd_sent
    tick(3);
    send_cmd(8'h10, 16'hBEEF, a);
    wait_sent(e);
    t0 = -1;
    for (int i = 0; i < 2100 && t0 < 0; i++) begin
      if (timeout === 1'b1) t0 = cyc;
      else tick(1);
    end
    check("t3_timeout_lat", 32'(t0 - e), 32'd2000);
    check("t3_rdy", resp_rdy, 1'b0);
    check("t3_busy", busy, 1'b0);

    // 4: snd_cmd while busy is ignored
    tick(3);
    send_cmd(8'h11, 16'h2233, a);
    tick(100);
    send_cmd(8'hFF, 16'hFFFF, t0);
    wait_sent(e);
    check("t4_cmd_sent_lat", 32'(e - a), 32'd480);
    send_rx(8'h77, 1'b1);
    wait_idle(400);
    check("t4_resp", resp, 8'h77);

    // 5: framing error discarded, next clean byte accepted
    tick(3);
    send_cmd(8'h21, 16'h0042, a);
    wait_sent(e);
    tick(5);
    send_rx(8'h5A, 1'b0);
    tick(10);
    check("t5_no_rdy", resp_rdy, 1'b0);
    check("t5_busy", busy, 1'b1);
    send_rx(8'h3C, 1'b1);
    wait_idle(400);
    check("t5_resp", resp, 8'h3C);
    check("t5_rdy", resp_rdy, 1'b1);

    // 6: reset during byte 1, then a full clean frame
    tick(3);
    send_cmd(8'h44, 16'h5566, a);
    tick(B * 10 + 40);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tx_async", TX, 1'b1);
    check("t6_busy_async", busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_cmd(8'hC3, 16'h0F81, a);
    capture(c0, c1, c2);
    check("t6_byte0", c0, 8'hC3);
    check("t6_byte1", c1, 8'h0F);
    check("t6_byte2", c2, 8'h81);
    wait_sent(e);
    send_rx(8'h69, 1'b1);
    wait_idle(400);
    check("t6_resp", resp, 8'h69);

    // 7: byte completing on the timeout cycle wins; one cycle later it loses
    tick(3);
    send_cmd(8'h33, 16'h1111, a);
    wait_sent(e);
    tick(TO - RXLAT);
    t0 = tmo_seen;
    send_rx(8'h96, 1'b1);
    wait_idle(400);
    check("t7_tie_resp", resp, 8'h96);
    check("t7_tie_rdy", resp_rdy, 1'b1);
    check("t7_tie_no_tmo", 32'(tmo_seen - t0), 32'd0);
    tick(3);
    send_cmd(8'h34, 16'h2222, a);
    wait_sent(e);
    tick(TO - RXLAT + 1);
    t0 = tmo_seen;
    send_rx(8'h55, 1'b1);
    wait_idle(400);
    check("t7_late_tmo", 32'(tmo_seen - t0), 32'd1);
    check("t7_late_rdy", resp_rdy, 1'b0);
    check("t7_late_resp", resp, 8'h96);

    // Randomized transactions
    for (int n = 0; n < 8; n++) begin
      int mode;
      tick(1 + $urandom_range(0, 5));
      send_cmd(8'($urandom), 16'($urandom), a);
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        tick($urandom_range(0, 100));
        send_rx(8'($urandom), 1'b1);
      end else if (mode == 2) begin
        tick($urandom_range(1, 300));
        send_cmd(8'($urandom), 16'($urandom), t0);
      end
      wait_sent(e);
      mode = $urandom_range(0, 3);
      if (mode != 3) begin
        tick($urandom_range(0, 500));
        if (mode == 1) send_rx(8'($urandom), 1'b0);
        send_rx(8'($urandom), 1'b1);
      end
      wait_idle(2200);
    end
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
